// File: rtl/module_decodificador.sv
// Hamming(7,4) single-error-correcting decoder.
// One-cycle registered pipeline; results hold while valid_in is low.
module module_decodificador (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [6:0] datos_cod,
  output logic       valid_out,
  output logic [3:0] datos_out,
  output logic [6:0] datos_corr,
  output logic [2:0] sindrome,
  output logic       error
);

  logic [2:0] syn;
  logic [6:0] corr;
  logic [3:0] dat;

  always_comb begin
    syn[0] = datos_cod[0] ^ datos_cod[2] ^ datos_cod[4] ^ datos_cod[6];
    syn[1] = datos_cod[1] ^ datos_cod[2] ^ datos_cod[5] ^ datos_cod[6];
    syn[2] = datos_cod[3] ^ datos_cod[4] ^ datos_cod[5] ^ datos_cod[6];
    corr   = datos_cod;
    // syndrome k points at Hamming position k, i.e. bit k-1
    for (int i = 0; i < 7; i++) begin
      if (syn == 3'(i + 1)) begin
        corr[i] = ~datos_cod[i];
      end
    end
    dat = {corr[6], corr[5], corr[4], corr[2]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out  <= 1'b0;
      datos_out  <= '0;
      datos_corr <= '0;
      sindrome   <= '0;
      error      <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        datos_out  <= dat;
        datos_corr <= corr;
        sindrome   <= syn;
        error      <= |syn;
      end
    end
  end

endmodule

// File: tb/tb_module_decodificador.sv
// Randomized and directed bench for the Hamming(7,4) decoder.
// A behavioural model predicts every cycle's outputs.
module tb_module_decodificador;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid_in = 1'b0;
  logic [6:0] datos_cod = '0;
  logic       valid_out;
  logic [3:0] datos_out;
  logic [6:0] datos_corr;
  logic [2:0] sindrome;
  logic       error;

  int checks = 0;
  int failures = 0;

  // tag: stimulus knows the original data and whether a bit was flipped
  logic       tag_in = 1'b0;
  logic [3:0] tag_dat = '0;
  logic       tag_flip = 1'b0;

  module_decodificador dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .datos_cod (datos_cod),
    .valid_out (valid_out),
    .datos_out (datos_out),
    .datos_corr(datos_corr),
    .sindrome  (sindrome),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // syndrome = XOR of the 1-based positions of all set bits
  function automatic logic [13:0] model_dec(input logic [6:0] c);
    logic [2:0] s;
    logic [6:0] k;
    s = '0;
    for (int i = 0; i < 7; i++)
      if (c[i]) s = s ^ 3'(i + 1);
    k = c;
    if (s != 0) k[s - 1] = ~k[s - 1];
    return {s, k, k[6], k[5], k[4], k[2]};
  endfunction

  // place data, then choose parity bits that zero the syndrome
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    logic [2:0] s;
    c = {d[3], d[2], d[1], 1'b0, d[0], 2'b00};
    s = model_dec(c)[13:11];
    c[0] = s[0];
    c[1] = s[1];
    c[3] = s[2];
    return c;
  endfunction

  logic       m_ok = 1'b0;
  logic       m_v;
  logic [3:0] m_dat;
  logic [6:0] m_corr;
  logic [2:0] m_s;
  logic       m_tag = 1'b0;
  logic [3:0] m_tdat;
  logic       m_tflip;

  always @(posedge clk) begin
    logic [13:0] r;
    if (rst) begin
      m_ok = 1'b1;
      m_v = 1'b0; m_dat = '0; m_corr = '0; m_s = '0; m_tag = 1'b0;
    end else begin
      m_v = valid_in;
      m_tag = valid_in && tag_in;
      m_tdat = tag_dat;
      m_tflip = tag_flip;
      if (valid_in) begin
        r = model_dec(datos_cod);
        m_s = r[13:11];
        m_corr = r[10:4];
        m_dat = r[3:0];
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("model_cycle",
          {valid_out, datos_out, datos_corr, sindrome, error},
          {m_v, m_dat, m_corr, m_s, m_s != 3'd0});
      if (m_tag) begin
        chk("orig_data", datos_out, m_tdat);
        chk("flip_flag", error, m_tflip);
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [6:0] c);
    @(negedge clk);
    rst = r;
    valid_in = v;
    datos_cod = c;
    tag_in = 1'b0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] c;
    chk("enc_0001", enc(4'b0001), 7'b000_0111);
    chk("enc_0010", enc(4'b0010), 7'b001_1001);

    step(1, 0, '0);
    after_edge();
    chk("reset_state", {valid_out, datos_out, datos_corr, sindrome, error}, '0);

    step(0, 1, 7'b000_0000);
    after_edge();
    chk("zero_word", {valid_out, datos_out, sindrome, error}, {1'b1, 8'b0});

    step(0, 1, 7'b000_0111);
    after_edge();
    chk("w0111_out", datos_out, 4'b0001);
    chk("w0111_corr", {datos_corr, sindrome, error}, {7'b000_0111, 4'b0});

    step(0, 1, 7'b001_1001);
    after_edge();
    chk("w11001_out", {datos_out, sindrome, error}, {4'b0010, 4'b0});

    step(0, 1, 7'b001_0111);
    after_edge();
    chk("w10111_syn", {sindrome, error}, {3'b101, 1'b1});
    chk("w10111_corr", {datos_corr, datos_out}, {7'b000_0111, 4'b0001});

    // exhaustive: every word, clean then each single-bit error, back-to-back
    for (int d = 0; d < 16; d++) begin
      for (int f = -1; f < 7; f++) begin
        c = enc(4'(d));
        if (f >= 0) c[f] = ~c[f];
        step(0, 1, c);
        tag_in = 1'b1;
        tag_dat = 4'(d);
        tag_flip = (f >= 0);
      end
    end

    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           7'($urandom));
    end

    // reset beats a concurrent valid word
    step(1, 1, 7'h55);
    after_edge();
    chk("rst_prio", {valid_out, datos_out, datos_corr, sindrome, error}, '0);

    c = enc(4'b0101);
    c[6] = ~c[6];
    step(0, 1, c);
    after_edge();
    chk("hold_first", {valid_out, datos_out, error}, {1'b1, 4'b0101, 1'b1});
    for (int n = 0; n < 3; n++) begin
      step(0, 0, 7'($urandom));
      after_edge();
      chk("hold_cycle",
          {valid_out, datos_out, datos_corr, sindrome, error},
          {1'b0, 4'b0101, enc(4'b0101), 3'd7, 1'b1});
    end

    step(0, 0, '0);
    after_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
